simo_unpack_fifo: RTL and testbench
===================================

SIMO_UNPACK_FIFO -- requirements
Module: simo_unpack_fifo

Interface
REQ-001 The module SHALL have parameter DEPTH, default 32, storage entries; power of two, minimum 8.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 8, element and input byte width.
REQ-003 The module SHALL have parameter DATA_LENGTH, default 9, number of output lanes.
REQ-004 The module SHALL have port i_clk  input  1  clock, rising edge.
REQ-005 The module SHALL have port i_nrst  input  1  reset, asynchronous, active-low.
REQ-006 The module SHALL have port i_clear  input  1  synchronous flush.
REQ-007 The module SHALL have port i_p_mode  input  2  precision mode: 00 = 8x8, 01 = 4x4, 10 = 2x2, 11 = reserved.
REQ-008 The module SHALL have port i_write_en  input  1  write request.
REQ-009 The module SHALL have port i_data  input  DATA_WIDTH  packed input byte.
REQ-010 The module SHALL have port i_pop_en  input  1  pop request.
REQ-011 The module SHALL have port i_pop_count  input  $clog2(DATA_LENGTH+1)  number of lanes requested.
REQ-012 The module SHALL have port o_data  output  DATA_LENGTH x DATA_WIDTH  lane data, registered.
REQ-013 The module SHALL have port o_valid  output  DATA_LENGTH  per-lane valid, registered.
REQ-014 The module SHALL have port o_count  output  $clog2(DEPTH)+1  stored element count.
REQ-015 The module SHALL have ports o_empty and o_full  output  1 each  status flags.

Function
REQ-016 Elements per write (E) SHALL be 1 in 8x8 mode, 2 in 4x4 mode, 4 in 2x2 mode, and 0 in reserved mode, where writes are ignored.
REQ-017 A write SHALL be accepted when i_write_en=1, E>0 and (DEPTH - o_count) >= E.
REQ-018 When a write is accepted, the E elements SHALL be stored at consecutive write-pointer locations, lowest sub-field first: 4x4 stores i_data[3:0], then [7:4]; 2x2 stores [1:0], [3:2], [5:4], [7:6].
REQ-019 Sub-byte elements SHALL be zero-extended to DATA_WIDTH (see REQ-035).
REQ-020 The write pointer SHALL advance by E, modulo DEPTH, with wrap-around mid-group allowed.
REQ-021 o_full SHALL equal (DEPTH - o_count) < E for the current i_p_mode, and SHALL be 1 in reserved mode.
REQ-022 o_empty SHALL equal (o_count == 0).
REQ-023 A pop SHALL occur when i_pop_en=1 and i_pop_count>0.
REQ-024 The number of popped elements n SHALL be min(i_pop_count clamped to DATA_LENGTH, o_count).
REQ-025 One cycle after a pop, lanes 0..n-1 SHALL hold elements in FIFO order with o_valid[i]=1, and the remaining lanes SHALL be 0 with o_valid=0.
REQ-026 In a cycle without a pop, o_valid SHALL be all zero and o_data SHALL hold its last value.
REQ-027 A pop on an empty FIFO SHALL return n=0 and all o_valid=0.
REQ-028 On simultaneous write and pop, both SHALL occur; the pop SHALL see only pre-cycle contents, and o_count SHALL update by E_accepted - n.
REQ-029 Write acceptance SHALL use the pre-cycle o_count; freed space is not usable in the same cycle.
REQ-030 i_p_mode SHALL be changeable at any time; stored elements are already unpacked and SHALL be unaffected.

Reset
REQ-031 On i_nrst=0, pointers, o_count, o_data and o_valid SHALL be 0 and o_empty SHALL be 1, asynchronously.
REQ-032 The storage array SHALL NOT be reset.
REQ-033 i_clear=1 SHALL produce the same register state at the next edge and SHALL take priority over same-cycle write and pop.
REQ-034 Reset asserted mid-operation SHALL discard all contents, including partial groups.

Configuration
REQ-035 When macro SIMO_SIGN_EXT_EN is defined, sub-byte elements SHALL be sign-extended (4x4 from bit 3, 2x2 from bit 1); when it is undefined, they SHALL be zero-extended; 8x8 mode SHALL be identical in both cases.

Verification
REQ-036 8x8 mode: write 0x11, 0x22, 0x33, then pop with count 9 -> lanes 0-2 = 11, 22, 33, o_valid = 9'b000000111, o_empty = 1.
REQ-037 4x4 mode: write 0xA5, then pop with count 2 -> lane0 = 0x05, lane1 = 0x0A (with SIMO_SIGN_EXT_EN: lane0 = 0x05, lane1 = 0xFA).
REQ-038 2x2 mode: write 0xE4, then pop with count 4 -> lanes = 00, 01, 02, 03 (sign-ext: 00, 01, FE, FF).
REQ-039 Full boundary, DEPTH=32, 2x2 mode: 8 writes -> o_count = 32, o_full = 1, 9th write ignored; after a pop with count 3 and no write, o_count = 29 and o_full = 1; after a further pop, o_count = 26 and o_full = 0.
REQ-040 Simultaneous write (8x8, 0x77) and pop with count 9 when o_count = 1 -> 1 lane valid containing the old element, o_count = 1 afterward.
REQ-041 Wrap-around and clear: fill and drain 30 elements in 8x8 mode, then a 4x4 write across the pointer wrap -> pop returns both nibbles in order; i_clear asserted with a write -> o_count = 0.

Source files
------------

// File: rtl/simo_unpack_fifo.sv
// Unpacking FIFO: packed bytes in (1/2/4 elements per write by precision mode), up to DATA_LENGTH lanes out per pop.
// Define SIMO_SIGN_EXT_EN to sign-extend sub-byte elements; otherwise they are zero-extended. Assumes DATA_WIDTH >= 8.
module simo_unpack_fifo #(
  parameter int DEPTH       = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_LENGTH = 9
) (
  input  logic                                     i_clk,
  input  logic                                     i_nrst,
  input  logic                                     i_clear,
  input  logic [1:0]                               i_p_mode,
  input  logic                                     i_write_en,
  input  logic [DATA_WIDTH-1:0]                    i_data,
  input  logic                                     i_pop_en,
  input  logic [$clog2(DATA_LENGTH+1)-1:0]         i_pop_count,
  output logic [DATA_LENGTH-1:0][DATA_WIDTH-1:0]   o_data,
  output logic [DATA_LENGTH-1:0]                   o_valid,
  output logic [$clog2(DEPTH):0]                   o_count,
  output logic                                     o_empty,
  output logic                                     o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0]                  mem_q [DEPTH];
  logic [PW-1:0]                          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                          count_q, count_d;
  logic [DATA_LENGTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_LENGTH-1:0]                 valid_q, valid_d;

  logic [31:0] elems_w;
  logic [31:0] free_w;
  logic [31:0] req_w;
  logic [31:0] n_w;
  logic        wr_accept;
  logic        pop_fire;

  logic [DATA_WIDTH-1:0] wr_elem [4];
  logic [DATA_WIDTH-1:0] rd_elem [DATA_LENGTH];

  function automatic logic [DATA_WIDTH-1:0] ext4(input logic [3:0] v);
`ifdef SIMO_SIGN_EXT_EN
    return {{(DATA_WIDTH-4){v[3]}}, v};
`else
    return {{(DATA_WIDTH-4){1'b0}}, v};
`endif
  endfunction

  function automatic logic [DATA_WIDTH-1:0] ext2(input logic [1:0] v);
`ifdef SIMO_SIGN_EXT_EN
    return {{(DATA_WIDTH-2){v[1]}}, v};
`else
    return {{(DATA_WIDTH-2){1'b0}}, v};
`endif
  endfunction

  always_comb begin
    case (i_p_mode)
      2'b00:   elems_w = 32'd1;
      2'b01:   elems_w = 32'd2;
      2'b10:   elems_w = 32'd4;
      default: elems_w = 32'd0;
    endcase
  end

  // Acceptance and pop size both use the pre-cycle count, so freed space is not reused this cycle.
  always_comb begin
    free_w    = 32'(DEPTH) - 32'(count_q);
    wr_accept = i_write_en && (elems_w != 32'd0) && (free_w >= elems_w);
    pop_fire  = i_pop_en && (i_pop_count != '0);
    req_w     = 32'(i_pop_count);
    if (req_w > 32'(DATA_LENGTH)) begin
      req_w = 32'(DATA_LENGTH);
    end
    n_w = 32'd0;
    if (pop_fire) begin
      n_w = (req_w < 32'(count_q)) ? req_w : 32'(count_q);
    end
    wr_ptr_d = wr_ptr_q + (wr_accept ? PW'(elems_w) : '0);
    rd_ptr_d = rd_ptr_q + PW'(n_w);
    count_d  = count_q + CW'(wr_accept ? elems_w : 32'd0) - CW'(n_w);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      logic [3:0] nib;
      logic [1:0] pair;
      assign nib  = i_data[4*(gi%2) +: 4];
      assign pair = i_data[2*gi +: 2];
      assign wr_elem[gi] = (i_p_mode == 2'b01) ? ext4(nib)  :
                           (i_p_mode == 2'b10) ? ext2(pair) : i_data;
    end

    for (gi = 0; gi < DATA_LENGTH; gi++) begin : g_lane
      assign rd_elem[gi] = mem_q[rd_ptr_q + PW'(gi)];
      assign valid_d[gi] = (32'(gi) < n_w);
      assign data_d[gi]  = valid_d[gi] ? rd_elem[gi] : '0;
    end
  endgenerate

  // Storage carries no reset; the pointers alone define what is live.
  always_ff @(posedge i_clk) begin
    if (wr_accept && !i_clear) begin
      for (int k = 0; k < 4; k++) begin
        if (32'(k) < elems_w) begin
          mem_q[wr_ptr_q + PW'(k)] <= wr_elem[k];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= '0;
    end else if (i_clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      if (pop_fire) begin
        data_q <= data_d;
      end
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_count = count_q;
  assign o_empty = (count_q == '0);
  assign o_full  = (i_p_mode == 2'b11) || (free_w < elems_w);

endmodule

// File: tb/tb_simo_unpack_fifo.sv
// Directed bench for simo_unpack_fifo (default parameters); expectations follow SIMO_SIGN_EXT_EN if defined.
module tb_simo_unpack_fifo;

  logic            clk = 1'b0;
  logic            nrst;
  logic            clear;
  logic [1:0]      mode;
  logic            write_en;
  logic [7:0]      data;
  logic            pop_en;
  logic [3:0]      pop_count;
  logic [8:0][7:0] odata;
  logic [8:0]      ovalid;
  logic [5:0]      ocount;
  logic            oempty;
  logic            ofull;

  int total = 0;
  int bad   = 0;

`ifdef SIMO_SIGN_EXT_EN
  localparam logic [7:0] A5_HI = 8'hFA;
  localparam logic [7:0] E4_2  = 8'hFE;
  localparam logic [7:0] E4_3  = 8'hFF;
  localparam logic [7:0] C3_LO = 8'hFC;
`else
  localparam logic [7:0] A5_HI = 8'h0A;
  localparam logic [7:0] E4_2  = 8'h02;
  localparam logic [7:0] E4_3  = 8'h03;
  localparam logic [7:0] C3_LO = 8'h0C;
`endif

  simo_unpack_fifo dut (
    .i_clk       (clk),
    .i_nrst      (nrst),
    .i_clear     (clear),
    .i_p_mode    (mode),
    .i_write_en  (write_en),
    .i_data      (data),
    .i_pop_en    (pop_en),
    .i_pop_count (pop_count),
    .o_data      (odata),
    .o_valid     (ovalid),
    .o_count     (ocount),
    .o_empty     (oempty),
    .o_full      (ofull)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] m, input logic [7:0] d);
    mode = m; data = d; write_en = 1'b1;
    tick();
    write_en = 1'b0;
  endtask

  task automatic pop(input logic [3:0] c);
    pop_count = c; pop_en = 1'b1;
    tick();
    pop_en = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; clear = 1'b0; mode = 2'b00; write_en = 1'b0;
    data = 8'h00; pop_en = 1'b0; pop_count = 4'd0;
    #12;
    chk("rst_count", 72'(ocount), 72'd0);
    chk("rst_empty", 72'(oempty), 72'd1);
    chk("rst_valid", 72'(ovalid), 72'd0);
    chk("rst_data", odata, 72'd0);
    chk("rst_full", 72'(ofull), 72'd0);
    @(negedge clk);
    nrst = 1'b1;
    tick();

    // 8x8 mode
    wr(2'b00, 8'h11); wr(2'b00, 8'h22); wr(2'b00, 8'h33);
    chk("m8_count3", 72'(ocount), 72'd3);
    pop(4'd9);
    chk("m8_valid", 72'(ovalid), 72'h007);
    chk("m8_data", odata, {6{8'h00}} == 48'd0 ? {48'd0, 8'h33, 8'h22, 8'h11} : 72'd0);
    chk("m8_empty", 72'(oempty), 72'd1);
    tick();
    chk("idle_valid", 72'(ovalid), 72'd0);
    chk("idle_hold", 72'(odata[0]), 72'h11);
    $display("m8 pop done count=%0d", ocount);

    // 4x4 mode
    wr(2'b01, 8'hA5);
    chk("m4_count", 72'(ocount), 72'd2);
    pop(4'd2);
    chk("m4_lane0", 72'(odata[0]), 72'h05);
    chk("m4_lane1", 72'(odata[1]), 72'(A5_HI));
    chk("m4_valid", 72'(ovalid), 72'h003);

    // 2x2 mode
    wr(2'b10, 8'hE4);
    pop(4'd4);
    chk("m2_lanes", 72'({odata[3], odata[2], odata[1], odata[0]}), 72'({E4_3, E4_2, 8'h01, 8'h00}));
    chk("m2_valid", 72'(ovalid), 72'h00F);

    // pop on empty
    pop(4'd5);
    chk("empty_pop_valid", 72'(ovalid), 72'd0);
    chk("empty_pop_data", odata, 72'd0);

    // full boundary in 2x2 mode
    for (int i = 0; i < 8; i++) wr(2'b10, 8'hE4);
    chk("full_count", 72'(ocount), 72'd32);
    chk("full_flag", 72'(ofull), 72'd1);
    wr(2'b10, 8'h00);
    chk("full_ignored", 72'(ocount), 72'd32);
    pop(4'd3);
    chk("full_pop1_count", 72'(ocount), 72'd29);
    chk("full_pop1_flag", 72'(ofull), 72'd1);
    chk("full_pop1_data", 72'({odata[2], odata[1], odata[0]}), 72'({E4_2, 8'h01, 8'h00}));
    pop(4'd3);
    chk("full_pop2_count", 72'(ocount), 72'd26);
    chk("full_pop2_flag", 72'(ofull), 72'd0);
    chk("full_pop2_data", 72'({odata[2], odata[1], odata[0]}), 72'({8'h01, 8'h00, E4_3}));
    mode = 2'b11;
    #1;
    chk("rsvd_full", 72'(ofull), 72'd1);
    wr(2'b11, 8'hFF);
    chk("rsvd_ignored", 72'(ocount), 72'd26);
    clear = 1'b1; pop_count = 4'd9; pop_en = 1'b1;
    tick();
    clear = 1'b0; pop_en = 1'b0;
    chk("clear_pop_count", 72'(ocount), 72'd0);
    chk("clear_pop_valid", 72'(ovalid), 72'd0);

    // simultaneous write and pop
    wr(2'b00, 8'h55);
    mode = 2'b00; data = 8'h77; write_en = 1'b1; pop_count = 4'd9; pop_en = 1'b1;
    tick();
    write_en = 1'b0; pop_en = 1'b0;
    chk("sim_valid", 72'(ovalid), 72'h001);
    chk("sim_lane0", 72'(odata[0]), 72'h55);
    chk("sim_count", 72'(ocount), 72'd1);
    pop(4'd9);
    chk("sim_next", 72'(odata[0]), 72'h77);

    // wrap-around: pointers at 2; fill/drain to land write pointer on 31
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 30; i++) wr(2'b00, 8'(i + 1));
    chk("wrap_fill", 72'(ocount), 72'd30);
    pop(4'd9); chk("wrap_d1", 72'(odata[0]), 72'd1);
    pop(4'd9); chk("wrap_d2", 72'(odata[0]), 72'd10);
    pop(4'd9); chk("wrap_d3", 72'(odata[0]), 72'd19);
    pop(4'd9);
    chk("wrap_d4_valid", 72'(ovalid), 72'h007);
    chk("wrap_d4_last", 72'(odata[2]), 72'd30);
    chk("wrap_drained", 72'(ocount), 72'd0);
    wr(2'b00, 8'h5A);
    wr(2'b01, 8'h3C);
    chk("wrap_count", 72'(ocount), 72'd3);
    pop(4'd3);
    chk("wrap_data", 72'({odata[2], odata[1], odata[0]}), 72'({8'h03, C3_LO, 8'h5A}));

    // clear with a same-cycle write
    wr(2'b00, 8'h01); wr(2'b00, 8'h02);
    clear = 1'b1; write_en = 1'b1; data = 8'h09;
    tick();
    clear = 1'b0; write_en = 1'b0;
    chk("clear_wr_count", 72'(ocount), 72'd0);
    chk("clear_wr_empty", 72'(oempty), 72'd1);
    chk("clear_wr_data", odata, 72'd0);

    // asynchronous reset mid-operation, including a partial 4x4 group
    wr(2'b01, 8'h12); wr(2'b00, 8'h34);
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_count", 72'(ocount), 72'd0);
    chk("arst_empty", 72'(oempty), 72'd1);
    @(negedge clk);
    nrst = 1'b1;
    pop(4'd9);
    chk("arst_pop_valid", 72'(ovalid), 72'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
